timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
- Shares one down-counting timer between NUM_REQ requesters.
- Arbitration is round-robin. A prescaler driven from the system clock sets the tick rate.
- Each requester asks for a timeout of load+1 ticks, holds the grant while its timeout runs, and receives a one-cycle done pulse when it expires.
- Sits in the timer subsystem, downstream of the clock generation logic; it sequences the shared counter resource for the blocks that need it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 12, width of timer counter and per-requester load value.
- PRESCALE_W, 8, width of prescale setting.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- prescale  input  PRESCALE_W  tick period minus one, in clk cycles; sampled every cycle.
- req  input  NUM_REQ  per-requester request level; held high until done or to abort.
- load  input  NUM_REQ*CNT_W  per-requester timeout; slice i is bits [i*CNT_W +: CNT_W].
- gnt  output  NUM_REQ  one-hot (or zero) owner of the timer.
- done  output  NUM_REQ  one-cycle expiry pulse to the owner.
- busy  output  1  high whenever gnt is non-zero.
- count  output  CNT_W  current timer value.
- tick  output  1  one-cycle pulse on each prescaler terminal count while RUN.

Behaviour:
- Reset (async, rst=1), all registers cleared:
  - state=IDLE; gnt=0; done=0; busy=0; count=0; tick=0; prescaler=0.
  - RR pointer set so requester 0 has highest priority.
- State IDLE:
  - If any req is high, the winner is the first set bit searching upward from (last_winner+1) mod NUM_REQ, wrapping.
  - Next cycle: gnt[winner]=1, count=load[winner] (sampled in the IDLE cycle), prescaler=0, state=RUN.
  - Grant latency is exactly 1 cycle from the req sample.
- State RUN:
  - Prescaler increments each cycle.
  - Tick condition: prescaler >= prescale. On a tick, prescaler returns to 0 and tick=1 for that cycle. Using >= means a prescale reduced mid-run ticks immediately.
  - On a tick with count!=0: count decrements by 1.
  - On a tick with count==0: state=DONE (expiry).
  - Total RUN duration = (load+1)*(prescale+1) cycles. load=0 gives 1 tick; prescale=0 gives a tick every cycle.
- State DONE (1 cycle):
  - done[owner]=1, gnt still held, count=0.
  - Next cycle: state=IDLE, gnt=0, busy=0, last_winner=owner.
- Abort:
  - req[owner]=0 in any RUN cycle → next cycle state=IDLE, gnt=0, no done pulse, last_winner=owner.
  - Abort and expiry in the same cycle: abort wins, no done.
- Re-request:
  - A requester still holding req in IDLE after its own done is treated as a new request.
  - The RR pointer places it last, so other pending requesters are served first.
- Non-owner req changes during RUN/DONE are ignored until IDLE.
- Mid-operation changes:
  - A load change during RUN has no effect.
  - A prescale change takes effect on the next comparison.
- Reset mid-run: immediate return to reset values; no done pulse.
- Counter arithmetic:
  - count never wraps below 0.
  - prescaler is PRESCALE_W bits and never exceeds prescale, except transiently after prescale is lowered; the >= compare handles that case.
- Invariants:
  - gnt is one-hot or zero.
  - done is a subset of gnt.
  - busy == |gnt.
  - tick is only high in RUN.

Test Plan:
1. Single requester: prescale=3, req[1]=1, load[1]=2.
   - Required: gnt=4'b0010 one cycle later.
   - tick every 4 cycles; count 2→1→0.
   - done[1] 12 cycles after grant; gnt drops the cycle after done.
2. Contention:
   - Stimulus: req=4'b1011 simultaneously from reset; prescale=0; all loads=1.
   - Grants in order 0,1,3, each holding 3 cycles (2 RUN + 1 DONE). Each requester drops its req on its done.
   - Next request from 0 is served after 3.
3. Fairness: req[0] and req[2] held permanently, load=0, prescale=0.
   - gnt alternates 0,2,0,2; no requester is granted twice in a row while another waits.
4. Abort:
   - Stimulus: req[2] granted with load=100, prescale=0; req[2] dropped after 10 cycles.
   - Required: gnt=0 next cycle, done stays 0, count frozen.
   - A pending req[3] is granted the cycle after that.
5. Abort at expiry: req[0], load=0, prescale=2; req[0] dropped in the cycle tick fires.
   - No done pulse; state returns to IDLE.
6. Reset mid-run: rst pulsed while count=5, asynchronously between clock edges.
   - gnt, done, busy, count and tick go to 0 immediately.
   - After release, req[3] and req[0] both pending → req[0] wins.

Source files
------------

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared, prescaled down-counter to NUM_REQ
// requesters; the owner keeps the grant until its timeout expires or it aborts.
module timer_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int CNT_W      = 12,
   parameter int PRESCALE_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PRESCALE_W-1:0]    prescale,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] load,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic [CNT_W-1:0]         count,
   output logic                     tick
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                state;
   logic [IDX_W-1:0]      owner;
   logic [IDX_W-1:0]      last_winner;
   logic [PRESCALE_W-1:0] prescaler;

   logic                  win_found;
   logic [IDX_W-1:0]      win_idx;
   logic [IDX_W-1:0]      cand_idx;
   logic [CNT_W-1:0]      load_sel;
   logic                  tick_now;
   int                    cand;

   // Search upward from the slot after the last winner, wrapping, so the
   // most recent owner always ends up with the lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_winner) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = cand[IDX_W-1:0];
         if (!win_found && req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   assign load_sel = load[win_idx*CNT_W +: CNT_W];

   // The >= compare lets a prescale lowered mid-run tick straight away.
   assign tick_now = (state == S_RUN) && (prescaler >= prescale);
   assign tick     = tick_now;
   assign busy     = |gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         gnt         <= '0;
         done        <= '0;
         count       <= '0;
         prescaler   <= '0;
         owner       <= '0;
         last_winner <= IDX_W'(NUM_REQ - 1);
      end else begin
         case (state)
            S_IDLE: begin
               done <= '0;
               if (win_found) begin
                  gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                  owner     <= win_idx;
                  count     <= load_sel;
                  prescaler <= '0;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               // Abort takes precedence over an expiry in the same cycle.
               if (!req[owner]) begin
                  gnt         <= '0;
                  last_winner <= owner;
                  state       <= S_IDLE;
               end else if (tick_now) begin
                  prescaler <= '0;
                  if (count == '0) begin
                     done  <= gnt;
                     state <= S_DONE;
                  end else begin
                     count <= count - 1'b1;
                  end
               end else begin
                  prescaler <= prescaler + 1'b1;
               end
            end
            S_DONE: begin
               done        <= '0;
               gnt         <= '0;
               last_winner <= owner;
               state       <= S_IDLE;
            end
            default: begin
               gnt   <= '0;
               done  <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus randomized traffic scored
// against a cycle-count model of the timeout rules.
module tb_timer_arbiter;

   localparam int N  = 4;
   localparam int CW = 12;
   localparam int PW = 8;

   logic          clk;
   logic          rst;
   logic [PW-1:0] prescale;
   logic [N-1:0]  req;
   logic [CW-1:0] ld [N];
   logic [N*CW-1:0] load;
   logic [N-1:0]  gnt;
   logic [N-1:0]  done;
   logic          busy;
   logic [CW-1:0] count;
   logic          tick;

   int n_tests;
   int n_fail;

   for (genvar g = 0; g < N; g++) begin : g_load
      assign load[g*CW +: CW] = ld[g];
   end

   timer_arbiter #(.NUM_REQ(N), .CNT_W(CW), .PRESCALE_W(PW)) dut (
      .clk(clk), .rst(rst), .prescale(prescale), .req(req), .load(load),
      .gnt(gnt), .done(done), .busy(busy), .count(count), .tick(tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      req      = '0;
      prescale = '0;
      for (int i = 0; i < N; i++) ld[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      prescale = '0;
      for (int i = 0; i < N; i++) ld[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({gnt, done, busy, count, tick} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt=%b done=%b busy=%b count=%0d tick=%b, required all zero",
                  gnt, done, busy, count, tick);
      end
      rst = 1'b0;
      step();
      n_tests++;
      if ({gnt, busy, tick} !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: gnt=%b busy=%b tick=%b, required 0 with no request", gnt, busy, tick);
      end
   endtask

   task automatic test_single();
      do_reset();
      prescale = 8'd3;
      ld[1]    = 12'd2;
      req      = 4'b0010;
      step();
      for (int k = 0; k < 12; k++) begin
         n_tests++;
         if (gnt !== 4'b0010 || done !== 4'b0000 || busy !== 1'b1 ||
             count !== CW'(2 - k / 4) || tick !== ((k % 4) == 3)) begin
            n_fail++;
            $display("FAIL single_run k=%0d: gnt=%b done=%b busy=%b count=%0d tick=%b, required gnt=0010 done=0000 busy=1 count=%0d tick=%b",
                     k, gnt, done, busy, count, tick, 2 - k / 4, (k % 4) == 3);
         end
         step();
      end
      n_tests++;
      if (done !== 4'b0010 || gnt !== 4'b0010 || count !== '0 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: done=%b gnt=%b count=%0d tick=%b, required done=0010 gnt=0010 count=0 tick=0",
                  done, gnt, count, tick);
      end
      req = '0;
      step();
      n_tests++;
      if (gnt !== '0 || done !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: gnt=%b done=%b busy=%b, required 0", gnt, done, busy);
      end
   endtask

   task automatic test_contention();
      int order [4];
      order = '{0, 1, 3, 0};
      do_reset();
      prescale = '0;
      for (int i = 0; i < N; i++) ld[i] = 12'd1;
      req = 4'b1011;
      for (int j = 0; j < 4; j++) begin
         logic [N-1:0] exp_g;
         exp_g = 4'(1 << order[j]);
         step();
         n_tests++;
         if (gnt !== exp_g || count !== 12'd1 || done !== '0) begin
            n_fail++;
            $display("FAIL contention_grant j=%0d: gnt=%b count=%0d done=%b, required gnt=%b count=1 done=0000",
                     j, gnt, count, done, exp_g);
         end
         step();
         n_tests++;
         if (gnt !== exp_g || count !== 12'd0 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL contention_run j=%0d: gnt=%b count=%0d tick=%b, required gnt=%b count=0 tick=1",
                     j, gnt, count, tick, exp_g);
         end
         step();
         n_tests++;
         if (done !== exp_g || gnt !== exp_g) begin
            n_fail++;
            $display("FAIL contention_done j=%0d: done=%b gnt=%b, required %b", j, done, gnt, exp_g);
         end
         req[order[j]] = 1'b0;
         step();
         n_tests++;
         if (gnt !== '0 || done !== '0) begin
            n_fail++;
            $display("FAIL contention_idle j=%0d: gnt=%b done=%b, required 0", j, gnt, done);
         end
         if (j == 0) req[0] = 1'b1;
      end
   endtask

   task automatic test_fairness();
      do_reset();
      prescale = '0;
      req = 4'b0101;
      for (int j = 0; j < 6; j++) begin
         logic [N-1:0] exp_g;
         exp_g = (j % 2 == 0) ? 4'b0001 : 4'b0100;
         step();
         n_tests++;
         if (gnt !== exp_g) begin
            n_fail++;
            $display("FAIL fairness_grant j=%0d: gnt=%b, required %b", j, gnt, exp_g);
         end
         step();
         n_tests++;
         if (done !== exp_g) begin
            n_fail++;
            $display("FAIL fairness_done j=%0d: done=%b, required %b", j, done, exp_g);
         end
         step();
      end
      req = '0;
      step();
   endtask

   task automatic test_abort();
      do_reset();
      prescale = '0;
      ld[2] = 12'd100;
      ld[3] = 12'd7;
      req = 4'b0100;
      step();
      n_tests++;
      if (gnt !== 4'b0100 || count !== 12'd100) begin
         n_fail++;
         $display("FAIL abort_grant: gnt=%b count=%0d, required gnt=0100 count=100", gnt, count);
      end
      req[3] = 1'b1;
      for (int k = 1; k < 10; k++) step();
      n_tests++;
      if (count !== 12'd91 || gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL abort_running: count=%0d gnt=%b, required count=91 gnt=0100", count, gnt);
      end
      req[2] = 1'b0;
      step();
      n_tests++;
      if (gnt !== '0 || done !== '0 || busy !== 1'b0 || count !== 12'd91) begin
         n_fail++;
         $display("FAIL abort_release: gnt=%b done=%b busy=%b count=%0d, required gnt=0 done=0 busy=0 count=91",
                  gnt, done, busy, count);
      end
      step();
      n_tests++;
      if (gnt !== 4'b1000 || count !== 12'd7 || done !== '0) begin
         n_fail++;
         $display("FAIL abort_next: gnt=%b count=%0d done=%b, required gnt=1000 count=7 done=0", gnt, count, done);
      end
      req = '0;
      step();
   endtask

   task automatic test_abort_at_expiry();
      do_reset();
      prescale = 8'd2;
      ld[0] = 12'd0;
      req = 4'b0001;
      step();
      step();
      step();
      n_tests++;
      if (tick !== 1'b1 || gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL expiry_tick: tick=%b gnt=%b, required tick=1 gnt=0001", tick, gnt);
      end
      req = '0;
      step();
      n_tests++;
      if (gnt !== '0 || done !== '0 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL expiry_abort: gnt=%b done=%b tick=%b, required all 0", gnt, done, tick);
      end
      step();
      n_tests++;
      if (gnt !== '0 || done !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL expiry_idle: gnt=%b done=%b busy=%b, required all 0", gnt, done, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      prescale = 8'd1;
      ld[1] = 12'd9;
      req = 4'b0010;
      repeat (9) step();
      n_tests++;
      if (count !== 12'd5 || gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL midreset_pre: count=%0d gnt=%b, required count=5 gnt=0010", count, gnt);
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({gnt, done, busy, count, tick} !== '0) begin
         n_fail++;
         $display("FAIL midreset_async: gnt=%b done=%b busy=%b count=%0d tick=%b, required all zero",
                  gnt, done, busy, count, tick);
      end
      req = 4'b1001;
      ld[0] = 12'd3;
      ld[3] = 12'd4;
      #1;
      rst = 1'b0;
      step();
      n_tests++;
      if (gnt !== 4'b0001 || count !== 12'd3) begin
         n_fail++;
         $display("FAIL midreset_winner: gnt=%b count=%0d, required gnt=0001 count=3", gnt, count);
      end
      req = '0;
      step();
   endtask

   // Reference: owner index (-1 when free), cycles elapsed since grant, and
   // the load latched at grant; ticks fall every (P+1) cycles.
   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int p, m_owner, m_el, m_L, m_last, m_hold, total;
         bit m_done;
         do_reset();
         p = $urandom_range(0, 3);
         prescale = PW'(p);
         m_owner = -1; m_el = 0; m_L = 0; m_last = N - 1; m_hold = 0; m_done = 1'b0;
         for (int cyc = 0; cyc < 300; cyc++) begin
            logic [N-1:0] eg, ed;
            logic [CW-1:0] ec;
            logic et;
            for (int i = 0; i < N; i++) begin
               if (i == m_owner && !m_done) req[i] = ($urandom_range(0, 29) != 0);
               else if (i == m_owner) req[i] = $urandom_range(0, 1);
               else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
               else req[i] = ($urandom_range(0, 9) != 0);
               if ($urandom_range(0, 2) == 0) ld[i] = CW'($urandom_range(0, 5));
            end
            if (m_owner < 0) begin
               bit found;
               found = 1'b0;
               for (int i = 1; i <= N; i++) begin
                  int c;
                  c = (m_last + i) % N;
                  if (!found && req[c[1:0]]) begin
                     found = 1'b1;
                     m_owner = c;
                     m_L = int'(ld[c[1:0]]);
                     m_el = 0;
                     m_done = 1'b0;
                  end
               end
            end else if (m_done) begin
               m_last = m_owner; m_owner = -1; m_hold = 0; m_done = 1'b0;
            end else if (!req[m_owner[1:0]]) begin
               m_hold = m_L - m_el / (p + 1);
               m_last = m_owner; m_owner = -1;
            end else begin
               total = (m_L + 1) * (p + 1);
               if (m_el + 1 == total) m_done = 1'b1;
               else m_el++;
            end
            if (m_owner < 0) begin
               eg = '0; ed = '0; ec = CW'(m_hold); et = 1'b0;
            end else if (m_done) begin
               eg = 4'(1 << m_owner); ed = eg; ec = '0; et = 1'b0;
            end else begin
               eg = 4'(1 << m_owner); ed = '0;
               ec = CW'(m_L - m_el / (p + 1));
               et = ((m_el + 1) % (p + 1)) == 0;
            end
            step();
            n_tests++;
            if (gnt !== eg || done !== ed || busy !== (|eg) || count !== ec || tick !== et) begin
               n_fail++;
               $display("FAIL random r=%0d cyc=%0d: gnt=%b done=%b busy=%b count=%0d tick=%b, required gnt=%b done=%b busy=%b count=%0d tick=%b",
                        r, cyc, gnt, done, busy, count, tick, eg, ed, |eg, ec, et);
            end
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      req = '0;
      prescale = '0;
      for (int i = 0; i < N; i++) ld[i] = '0;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_abort();
      test_abort_at_expiry();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
